// File: rtl/arp_resolver_if.sv
// arp_resolver_if: request/response, cache-query, ARP-trigger and config signals of the ARP resolver
interface arp_resolver_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_ip;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_error;
  logic [47:0] resp_mac;
  logic        query_request_valid;
  logic        query_request_ready;
  logic [31:0] query_request_ip;
  logic        query_response_valid;
  logic        query_response_ready;
  logic        query_response_error;
  logic [47:0] query_response_mac;
  logic        arp_req_valid;
  logic        arp_req_ready;
  logic [31:0] arp_req_ip;
  logic [31:0] local_ip;
  logic [31:0] gateway_ip;
  logic [31:0] subnet_mask;
  modport master (
    output req_valid, req_ip, resp_ready, query_request_ready, query_response_valid,
           query_response_error, query_response_mac, arp_req_ready, local_ip, gateway_ip, subnet_mask,
    input  req_ready, resp_valid, resp_error, resp_mac, query_request_valid, query_request_ip,
           query_response_ready, arp_req_valid, arp_req_ip
  );
  modport slave (
    input  req_valid, req_ip, resp_ready, query_request_ready, query_response_valid,
           query_response_error, query_response_mac, arp_req_ready, local_ip, gateway_ip, subnet_mask,
    output req_ready, resp_valid, resp_error, resp_mac, query_request_valid, query_request_ip,
           query_response_ready, arp_req_valid, arp_req_ip
  );
endinterface

// File: rtl/arp_resolver.sv
// arp_resolver: resolves next-hop MACs via the ARP cache, issuing ARP requests and retrying on misses
module arp_resolver #(
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 250000,
  parameter int TIMER_WIDTH    = 32
) (
  input logic           clk,
  input logic           rst_n,
  arp_resolver_if.slave bus
);
  localparam int CW = RETRY_COUNT > 0 ? $clog2(RETRY_COUNT + 1) : 1;
  localparam logic [CW-1:0] RC = CW'(RETRY_COUNT);
  localparam logic [TIMER_WIDTH-1:0] RELOAD = TIMER_WIDTH'(RETRY_INTERVAL - 1);
  typedef enum logic [2:0] {IDLE, QUERY, WAIT_RESP, SEND_ARP, WAIT_RETRY, RESPOND} state_t;
  state_t state, state_n;
  logic [31:0] target, target_n;
  logic [CW-1:0] retry_cnt, retry_n;
  logic [TIMER_WIDTH-1:0] timer, timer_n;
  logic [47:0] mac, mac_n;
  logic err, err_n, rdy, on_sub, bcast;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      mac       <= '0;
      err       <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      retry_cnt <= retry_n;
      timer     <= timer_n;
      mac       <= mac_n;
      err       <= err_n;
      rdy       <= state_n == IDLE;
    end
  end
  always_comb begin
    on_sub   = ((bus.req_ip ^ bus.local_ip) & bus.subnet_mask) == '0;
    bcast    = &bus.req_ip || (on_sub && &(bus.req_ip | bus.subnet_mask));
    state_n  = state;
    target_n = target;
    retry_n  = retry_cnt;
    timer_n  = timer;
    mac_n    = mac;
    err_n    = err;
    case (state)
      IDLE: if (bus.req_valid && rdy) begin
        retry_n  = '0;
        mac_n    = bcast ? '1 : '0;
        err_n    = !bcast && !on_sub && bus.gateway_ip == '0;
        target_n = on_sub ? bus.req_ip : bus.gateway_ip;
        state_n  = (bcast || err_n) ? RESPOND : QUERY;
      end
      QUERY: state_n = bus.query_request_ready ? WAIT_RESP : QUERY;
      WAIT_RESP: if (bus.query_response_valid) begin
        mac_n   = bus.query_response_error ? '0 : bus.query_response_mac;
        err_n   = bus.query_response_error;
        state_n = (bus.query_response_error && retry_cnt != RC) ? SEND_ARP : RESPOND;
      end
      SEND_ARP: if (bus.arp_req_ready) begin
        retry_n = retry_cnt == RC ? retry_cnt : retry_cnt + 1'b1;
        timer_n = RELOAD;
        state_n = WAIT_RETRY;
      end
      WAIT_RETRY: begin
        timer_n = timer == '0 ? timer : timer - 1'b1;
        state_n = timer == '0 ? QUERY : WAIT_RETRY;
      end
      RESPOND: state_n = bus.resp_ready ? IDLE : RESPOND;
      default: state_n = IDLE;
    endcase
  end
  assign bus.req_ready            = rdy;
  assign bus.resp_valid           = state == RESPOND;
  assign bus.resp_error           = err;
  assign bus.resp_mac             = mac;
  assign bus.query_request_valid  = state == QUERY;
  assign bus.query_request_ip     = target;
  assign bus.query_response_ready = state == WAIT_RESP;
  assign bus.arp_req_valid        = state == SEND_ARP;
  assign bus.arp_req_ip           = target;
endmodule
